approx_mul_rr_scheduler: RTL and testbench

// Shares one combinational unsigned 8x8 approximate multiplier core among N_REQ requesters.

---
 rtl/approx_mul_rr_scheduler.sv | 134 +++++++++++++
 tb/tb_approx_mul_rr_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_rr_scheduler.sv
// Round-robin front end that shares one combinational 8x8 multiplier core among N_REQ issue ports.
// Ops are registered into the core, products are queued in an in-order response FIFO.
module approx_mul_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_x,
    input  logic [8*N_REQ-1:0]   req_y,
    output logic [7:0]           mul_x,
    output logic [7:0]           mul_y,
    input  logic [15:0]          mul_z,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_z,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            credit_ok;
    logic [7:0]      sel_x;
    logic [7:0]      sel_y;

    logic            vld_p1;
    logic [7:0]      x_p1;
    logic [7:0]      y_p1;
    logic [ID_W-1:0] id_p1;

    logic [15:0]     fifo_z  [DEPTH];
    logic [ID_W-1:0] fifo_id [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     fifo_count;
    logic            push;
    logic            pop;

    // Credit counts everything in flight before this cycle's pop, so the FIFO can never overflow.
    assign credit_ok = (({{PW{1'b0}}, vld_p1} + fifo_count) < (PW+1)'(DEPTH));

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (rst_n && credit_ok) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = ID_W'((int'(ptr) + k) % N_REQ);
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found) req_ready[grant_idx] = 1'b1;
    end

    assign sel_x = req_x[8*grant_idx +: 8];
    assign sel_y = req_y[8*grant_idx +: 8];

    assign push      = vld_p1;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = (fifo_count != '0);
    assign rsp_z     = fifo_z[rd_ptr];
    assign rsp_id    = fifo_id[rd_ptr];
    assign busy      = vld_p1 | (fifo_count != '0);
    assign mul_x     = x_p1;
    assign mul_y     = y_p1;

    // Stage p1: granted operands drive the shared core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            vld_p1 <= 1'b0;
            x_p1   <= '0;
            y_p1   <= '0;
            id_p1  <= '0;
        end else begin
            vld_p1 <= grant_found;
            if (grant_found) begin
                ptr   <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                x_p1  <= sel_x;
                y_p1  <= sel_y;
                id_p1 <= grant_idx;
            end
        end
    end

    // Stage p2: core product captured into the response FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_z[i]  <= '0;
                fifo_id[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            op_count   <= '0;
        end else begin
            if (push) begin
                fifo_z[wr_ptr]  <= mul_z;
                fifo_id[wr_ptr] <= id_p1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                op_count <= sat_inc(op_count);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_mul_rr_scheduler.sv
// Bench for approx_mul_rr_scheduler: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_approx_mul_rr_scheduler;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int DEPTH = 2;
    // Narrow counter so saturation is reached in a few hundred responses.
    localparam int CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [8*N_REQ-1:0]   req_x;
    logic [8*N_REQ-1:0]   req_y;
    logic [7:0]           mul_x;
    logic [7:0]           mul_y;
    logic [15:0]          mul_z;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_z;
    logic                 busy;
    logic [CNT_W-1:0]     op_count;

    always #5 clk = ~clk;

    // Stand-in approximate core: exact product with the two LSBs dropped.
    function automatic logic [15:0] core_mul(input logic [7:0] a, input logic [7:0] b);
        return (16'(a) * 16'(b)) & 16'hFFFC;
    endfunction

    assign mul_z = core_mul(mul_x, mul_y);

    approx_mul_rr_scheduler #(
        .N_REQ(N_REQ), .ID_W(ID_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_z(rsp_z),
        .busy(busy), .op_count(op_count)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // Reference model: every accepted op waits in an in-order queue and becomes
    // visible two cycles after its handshake; capacity is DEPTH ops in flight.
    typedef struct {
        logic [ID_W-1:0] id;
        logic [15:0]     z;
        int              avail;
    } rsp_t;

    rsp_t       q[$];
    int         m_ptr = 0;
    logic [7:0] m_x = 8'd0;
    logic [7:0] m_y = 8'd0;
    int         m_cnt = 0;
    int         cyc = 0;

    always @(negedge clk) begin
        int               g;
        int               c;
        logic [N_REQ-1:0] e_ready;
        logic             e_valid;
        rsp_t             e;
        if (!rst_n) begin
            q.delete();
            m_ptr = 0;
            m_x   = 8'd0;
            m_y   = 8'd0;
            m_cnt = 0;
        end else begin
            g = -1;
            if (q.size() < DEPTH) begin
                for (int k = 0; k < N_REQ; k++) begin
                    c = (m_ptr + k) % N_REQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            e_ready = (g >= 0) ? (N_REQ'(1) << g) : '0;
            e_valid = (q.size() > 0) && (q[0].avail <= cyc);
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
            chk("busy", 32'(busy), 32'(q.size() > 0));
            chk("mul_x", 32'(mul_x), 32'(m_x));
            chk("mul_y", 32'(mul_y), 32'(m_y));
            chk("op_count", 32'(op_count), 32'(m_cnt));
            if (e_valid) begin
                chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                chk("rsp_z", 32'(rsp_z), 32'(q[0].z));
            end
            if (e_valid && rsp_ready) begin
                void'(q.pop_front());
                if (m_cnt < (2**CNT_W) - 1) m_cnt++;
            end
            if (g >= 0) begin
                e.id    = ID_W'(g);
                e.z     = core_mul(req_x[8*g +: 8], req_y[8*g +: 8]);
                e.avail = cyc + 2;
                q.push_back(e);
                m_x   = req_x[8*g +: 8];
                m_y   = req_y[8*g +: 8];
                m_ptr = (g + 1) % N_REQ;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    function automatic int grant_index(input logic [N_REQ-1:0] r);
        int gi = -1;
        for (int k = 0; k < N_REQ; k++) if (r[k]) gi = k;
        return gi;
    endfunction

    int grants[6];
    int exp_seq[6] = '{1, 2, 3, 0, 1, 2};
    int ngr;
    bit found;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;
        repeat (2) at_neg();
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_mul_x", 32'(mul_x), 32'(0));
        chk("rst_mul_y", 32'(mul_y), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_id", 32'(rsp_id), 32'(0));
        chk("rst_rsp_z", 32'(rsp_z), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_op_count", 32'(op_count), 32'(0));

        // Single op from requester 0: 200*100 = 20000 = 0x4E20
        tick();
        rst_n      = 1'b1;
        req_x[7:0] = 8'd200;
        req_y[7:0] = 8'd100;
        req_valid  = 4'b0001;
        rsp_ready  = 1'b1;
        at_neg();
        chk("t1_grant", 32'(req_ready), 32'(4'b0001));
        tick();
        req_valid = '0;
        at_neg();
        chk("t1_mul_x", 32'(mul_x), 32'(200));
        chk("t1_mul_y", 32'(mul_y), 32'(100));
        chk("t1_early_rsp", 32'(rsp_valid), 32'(0));
        tick();
        at_neg();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("t1_rsp_id", 32'(rsp_id), 32'(0));
        chk("t1_rsp_z", 32'(rsp_z), 32'(16'h4E20));
        tick();
        at_neg();
        chk("t1_one_only", 32'(rsp_valid), 32'(0));
        chk("t1_count", 32'(op_count), 32'(1));
        chk("t1_idle", 32'(busy), 32'(0));

        // All requesters asserted: pointer sits at 1 after the grant to 0
        for (int i = 0; i < 6; i++) grants[i] = -1;
        ngr = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            req_valid = 4'b1111;
            req_x     = $urandom;
            req_y     = $urandom;
            at_neg();
            if (req_ready != '0 && ngr < 6) begin
                grants[ngr] = grant_index(req_ready);
                ngr++;
            end
        end
        for (int i = 0; i < 6; i++) chk("t2_rr_order", 32'(grants[i]), 32'(exp_seq[i]));
        tick();
        req_valid = '0;
        repeat (4) begin tick(); at_neg(); end
        chk("t2_drained", 32'(busy), 32'(0));

        // Grant 2, then 3 must come before 1
        tick();
        req_valid = 4'b0100;
        at_neg();
        chk("t4_grant2", 32'(req_ready), 32'(4'b0100));
        tick();
        req_valid = 4'b1010;
        at_neg();
        chk("t4_grant3", 32'(req_ready), 32'(4'b1000));
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!found) begin
                tick();
                at_neg();
                if (req_ready != '0) begin
                    found = 1'b1;
                    chk("t4_grant1", 32'(req_ready), 32'(4'b0010));
                end
            end
        end
        if (!found) chk("t4_grant1_timeout", 32'(req_ready), 32'(4'b0010));
        tick();
        req_valid = '0;
        repeat (4) begin tick(); at_neg(); end

        // Backpressure: only DEPTH ops accepted, head holds, drain resumes issue
        tick();
        rsp_ready  = 1'b0;
        req_valid  = 4'b0001;
        req_x[7:0] = 8'd3;
        req_y[7:0] = 8'd5;
        at_neg();
        chk("t3_acc1", 32'(req_ready), 32'(4'b0001));
        tick();
        req_x[7:0] = 8'd10;
        req_y[7:0] = 8'd10;
        at_neg();
        chk("t3_acc2", 32'(req_ready), 32'(4'b0001));
        tick();
        req_x[7:0] = 8'd50;
        req_y[7:0] = 8'd50;
        at_neg();
        chk("t3_blocked", 32'(req_ready), 32'(0));
        repeat (5) begin
            tick();
            at_neg();
            chk("t3_blocked", 32'(req_ready), 32'(0));
            chk("t3_head_z", 32'(rsp_z), 32'(16'd12));
            chk("t3_head_id", 32'(rsp_id), 32'(0));
        end
        tick();
        rsp_ready = 1'b1;
        at_neg();
        chk("t3_drain_z0", 32'(rsp_z), 32'(16'd12));
        chk("t3_no_credit", 32'(req_ready), 32'(0));
        tick();
        at_neg();
        chk("t3_drain_z1", 32'(rsp_z), 32'(16'd100));
        chk("t3_resume", 32'(req_ready), 32'(4'b0001));
        tick();
        req_valid = '0;
        repeat (4) begin tick(); at_neg(); end

        // Saturating counter
        for (int i = 0; i < 600; i++) begin
            tick();
            req_valid = 4'b1111;
            rsp_ready = 1'b1;
            req_x     = $urandom;
            req_y     = $urandom;
            at_neg();
        end
        chk("t6_saturated", 32'(op_count), 32'(8'hFF));

        // Async reset with FIFO full
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (4) begin tick(); at_neg(); end
        chk("t5_full_valid", 32'(rsp_valid), 32'(1));
        chk("t5_full_busy", 32'(busy), 32'(1));
        chk("t5_full_ready", 32'(req_ready), 32'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(rsp_valid), 32'(0));
        chk("t5_async_busy", 32'(busy), 32'(0));
        chk("t5_async_ready", 32'(req_ready), 32'(0));
        chk("t5_async_count", 32'(op_count), 32'(0));
        chk("t5_async_mul_x", 32'(mul_x), 32'(0));
        at_neg();
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        at_neg();
        chk("t5_first_grant", 32'(req_ready), 32'(4'b0001));
        chk("t5_count", 32'(op_count), 32'(0));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            req_valid = 4'($urandom);
            req_x     = $urandom;
            req_y     = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 7);
            at_neg();
        end
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) begin tick(); at_neg(); end
        chk("end_idle", 32'(busy), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
